prim_rom_rd_adapter: RTL and testbench

- Read front-end that sits directly upstream of the generic ROM primitive. It drives that primitive's address/chip-select and consumes its data/valid outputs.
- Converts a req/gnt request channel plus a valid/ready response channel into the ROM's fixed one-cycle read protocol.
- Buffers read data in a small in-order response FIFO, so the ROM never needs backpressure.
- Used by fetch/boot logic that cannot guarantee it will accept data the cycle after it issues a read.

---
 rtl/prim_rom_rd_adapter.sv | 148 ++++++++++++++
 tb/tb_prim_rom_rd_adapter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_rom_rd_adapter.sv
// prim_rom_rd_adapter
//   Read front-end for the generic ROM primitive. It turns a req/gnt request
//   channel and a valid/ready response channel into the ROM's fixed one-cycle
//   read protocol. Read data is buffered in a small in-order response FIFO, so
//   the ROM never sees backpressure.
//
//   Optional feature macro: PRIM_ROM_RD_ADDR_CHK_EN
//     When defined, requests with addr_i >= Depth are still granted, but they
//     do not select the ROM. They return data 0 with rsp_err_o=1, in order
//     with the other responses. The rsp_err_o port exists only in this build.
//
// Ports
//   clk_i, rst_i   clock; asynchronous active-high reset
//   req_i, addr_i  read request and word address
//   gnt_o          request accepted this cycle (combinational, may follow rsp_ready_i)
//   rsp_valid_o    response FIFO head valid
//   rsp_ready_i    consumer accepts the head
//   rsp_data_o     head data
//   rsp_err_o      head error flag (PRIM_ROM_RD_ADDR_CHK_EN only)
//   rom_cs_o       ROM chip select
//   rom_addr_o     ROM address
//   rom_dout_i     ROM read data, one cycle after rom_cs_o
//   rom_dvalid_i   ROM data valid, one cycle after rom_cs_o
module prim_rom_rd_adapter #(
  parameter int Width    = 32,
  parameter int Depth    = 2048,
  parameter int Aw       = $clog2(Depth),
  parameter int RspDepth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [Aw-1:0]    addr_i,
  output logic             gnt_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_data_o,
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
  output logic             rsp_err_o,
`endif
  output logic             rom_cs_o,
  output logic [Aw-1:0]    rom_addr_o,
  input  logic [Width-1:0] rom_dout_i,
  input  logic             rom_dvalid_i
);

  localparam int CntW = $clog2(RspDepth + 1) + 1;
  localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [CntW-1:0] RspDepthC = CntW'(RspDepth);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(RspDepth - 1);

  logic             pend_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [Width-1:0] data_q [RspDepth];
  logic             grant, pop, push;
  logic             req_err, pend_err;
  logic [Width-1:0] push_data;

`ifdef PRIM_ROM_RD_ADDR_CHK_EN
  logic pend_err_q;
  logic err_q [RspDepth];

  assign req_err  = ({1'b0, addr_i} >= (Aw + 1)'(Depth));
  assign pend_err = pend_err_q;
`else
  assign req_err  = 1'b0;
  assign pend_err = 1'b0;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign pop  = rsp_valid_o & rsp_ready_i;
  assign push = pend_q;

  // Occupancy after this cycle: buffered + in flight - leaving now. The
  // in-flight read always lands, so it must already own a slot at grant time.
  // Gating with rst_i forces the combinational outputs low during reset.
  assign grant = req_i & ~rst_i &
                 ((count_q + CntW'(pend_q) - CntW'(pop)) < RspDepthC);

  assign gnt_o      = grant;
  assign rom_cs_o   = grant & ~req_err;
  assign rom_addr_o = (req_i & ~rst_i) ? addr_i : '0;

  assign rsp_valid_o = (count_q != '0);
  assign rsp_data_o  = rsp_valid_o ? data_q[rd_ptr_q] : '0;
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
  assign rsp_err_o   = rsp_valid_o & err_q[rd_ptr_q];
`endif

  // Capture is keyed on pend_q; rom_dvalid_i is only cross-checked.
  assign push_data = pend_err ? '0 : rom_dout_i;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
      pend_err_q <= 1'b0;
`endif
    end else begin
      pend_q   <= grant;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
      pend_err_q <= grant & req_err;
`endif
    end
  end

  // FIFO storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= push_data;
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
      err_q[wr_ptr_q]  <= pend_err;
`endif
    end
  end

  rom_dvalid_chk: assert property (@(posedge clk_i) disable iff (rst_i)
                                   rom_dvalid_i == (pend_q & ~pend_err));

endmodule

// File: tb/tb_prim_rom_rd_adapter.sv
module tb_prim_rom_rd_adapter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = $clog2(DEPTH);
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  int   cyc = 0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  // DUT0: RspDepth=2
  logic             req_i, gnt_o, rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic             rom_cs_o, rom_dvalid_i;
  logic [AW-1:0]    addr_i, rom_addr_o;
  logic [WIDTH-1:0] rsp_data_o, rom_dout_i;

  // DUT1: RspDepth=1
  logic             req1, gnt1, valid1, ready1, rom_cs1, rom_dvalid1;
  logic [AW-1:0]    addr1, rom_addr1;
  logic [WIDTH-1:0] data1, rom_dout1;
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
  logic             err1;
`else
  assign rsp_err_o = 1'b0;
`endif

  prim_rom_rd_adapter #(.Width(WIDTH), .Depth(DEPTH), .RspDepth(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
    .rsp_err_o   (rsp_err_o),
`endif
    .rom_cs_o    (rom_cs_o),
    .rom_addr_o  (rom_addr_o),
    .rom_dout_i  (rom_dout_i),
    .rom_dvalid_i(rom_dvalid_i)
  );

  prim_rom_rd_adapter #(.Width(WIDTH), .Depth(DEPTH), .RspDepth(1)) dut1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req1),
    .addr_i      (addr1),
    .gnt_o       (gnt1),
    .rsp_valid_o (valid1),
    .rsp_ready_i (ready1),
    .rsp_data_o  (data1),
`ifdef PRIM_ROM_RD_ADDR_CHK_EN
    .rsp_err_o   (err1),
`endif
    .rom_cs_o    (rom_cs1),
    .rom_addr_o  (rom_addr1),
    .rom_dout_i  (rom_dout1),
    .rom_dvalid_i(rom_dvalid1)
  );

  // ROM contents; out-of-range addresses wrap.
  function automatic logic [WIDTH-1:0] rom_word(input int unsigned a);
    int unsigned w;
    w = a % DEPTH;
    if (w == 16) return 32'hDEADBEEF;
    return (w * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Reference response for a granted address: {err, data}
  function automatic logic [WIDTH:0] exp_rsp(input int unsigned a);
    if (CHK && a >= DEPTH) return {1'b1, {WIDTH{1'b0}}};
    return {1'b0, rom_word(a)};
  endfunction

  // Behavioural ROMs: one-cycle registered read
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rom_dvalid_i <= 1'b0; rom_dout_i <= '0;
      rom_dvalid1  <= 1'b0; rom_dout1  <= '0;
    end else begin
      rom_dvalid_i <= rom_cs_o;
      rom_dout_i   <= rom_cs_o ? rom_word(rom_addr_o) : '0;
      rom_dvalid1  <= rom_cs1;
      rom_dout1    <= rom_cs1 ? rom_word(rom_addr1) : '0;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               gcyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor DUT0: a response is valid once its grant is at least 2 cycles old;
  // a grant is due when outstanding responses after this cycle's pop fit in 2.
  always @(negedge clk_i) begin
    if (rst_i) begin
      q0.delete();
    end else begin
      bit          ev, eg, ee, pp;
      exp_t        e;
      int unsigned a;
      ev = (q0.size() > 0) && (q0[0].gcyc + 2 <= cyc);
      chk("rsp_valid", rsp_valid_o, ev);
      if (ev) begin
        chk("rsp_data", rsp_data_o, q0[0].data);
        chk("rsp_err", rsp_err_o, q0[0].err);
      end
      pp = ev && rsp_ready_i;
      eg = req_i && (q0.size() - int'(pp) < 2);
      a  = addr_i;
      ee = CHK && (a >= DEPTH);
      chk("gnt", gnt_o, eg);
      chk("rom_cs", rom_cs_o, eg && !ee);
      chk("rom_addr", rom_addr_o, req_i ? addr_i : '0);
      if (pp) void'(q0.pop_front());
      if (eg) begin
        {e.err, e.data} = exp_rsp(a);
        e.gcyc = cyc;
        q0.push_back(e);
      end
    end
  end

  // Monitor DUT1 (single-entry FIFO)
  always @(negedge clk_i) begin
    if (rst_i) begin
      q1.delete();
    end else begin
      bit   ev, eg, pp;
      exp_t e;
      ev = (q1.size() > 0) && (q1[0].gcyc + 2 <= cyc);
      chk("d1_valid", valid1, ev);
      if (ev) chk("d1_data", data1, q1[0].data);
      pp = ev && ready1;
      eg = req1 && (q1.size() - int'(pp) < 1);
      chk("d1_gnt", gnt1, eg);
      if (pp) void'(q1.pop_front());
      if (eg) begin
        {e.err, e.data} = exp_rsp(addr1);
        e.gcyc = cyc;
        q1.push_back(e);
      end
    end
  end

  int unsigned aq[$];
  bit          rst_done = 1'b0;
  bit          done1    = 1'b0;

  // mode 0: ready=1; mode 1: ready=0 for 'hold' cycles then 1; mode 2: random
  task automatic run_list(input int mode, input int hold, output int g_hold, output bit g_at);
    int c;
    c = 0; g_hold = 0; g_at = 1'b0;
    while (aq.size() > 0 && c < 2000) begin
      @(posedge clk_i); #1;
      case (mode)
        0:       rsp_ready_i = 1'b1;
        1:       rsp_ready_i = (c >= hold);
        default: rsp_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (mode != 2 || $urandom_range(0, 3) != 0) begin
        req_i = 1'b1; addr_i = AW'(aq[0]);
      end else begin
        req_i = 1'b0; addr_i = AW'($urandom);
      end
      @(negedge clk_i);
      if (gnt_o) begin
        void'(aq.pop_front());
        if (c < hold) g_hold++;
        if (c == hold) g_at = 1'b1;
      end
      c++;
    end
    @(posedge clk_i); #1;
    req_i = 1'b0; addr_i = '0;
    chk("list_done", aq.size(), 0);
  endtask

  task automatic drain();
    int c;
    c = 0;
    rsp_ready_i = 1'b1; req_i = 1'b0;
    while (q0.size() > 0 && c < 50) begin
      @(negedge clk_i); c++;
    end
    chk("drain", q0.size(), 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (%0d checks)", checks);
    $fatal(1, "timeout");
  end

  // DUT1: continuous requests with ready=1 -> one grant every other cycle
  initial begin
    int g1;
    g1 = 0;
    req1 = 1'b0; addr1 = '0; ready1 = 1'b1;
    wait (rst_done);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk_i); #1;
      req1 = 1'b1; addr1 = AW'(40 + g1);
      @(negedge clk_i);
      if (gnt1) g1++;
    end
    @(posedge clk_i); #1;
    req1 = 1'b0;
    chk("d1_grants", g1, 12);
    repeat (4) @(posedge clk_i);
    done1 = 1'b1;
  end

  initial begin
    int g;
    bit at;
    rst_i = 1'b0; req_i = 1'b1; addr_i = AW'(16); rsp_ready_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_data", rsp_data_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_cs", rom_cs_o, 0);
    chk("rst_addr", rom_addr_o, 0);
    req_i = 1'b0; addr_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    rst_done = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;

    // single read of 0x10
    aq = '{16};
    run_list(0, 1, g, at);
    chk("single_gnt", g, 1);
    drain();

    // streaming 0..7
    for (int i = 0; i < 8; i++) aq.push_back(i);
    run_list(0, 8, g, at);
    chk("stream_grants", g, 8);
    drain();

    // backpressure: ready low for 6 cycles
    for (int i = 0; i < 4; i++) aq.push_back(100 + i);
    run_list(1, 6, g, at);
    chk("bp_grants", g, 2);
    chk("bp_resume_gnt", at, 1);
    drain();

    // boundary addresses around DEPTH
    aq = '{999, 1000, 5, 1023, 0};
    run_list(0, 5, g, at);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) aq.push_back($urandom_range(0, 1023));
    run_list(2, 0, g, at);
    drain();

    // reset with reads in flight and buffered
    rsp_ready_i = 1'b0; req_i = 1'b1; addr_i = AW'(7);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_gnt", gnt_o, 0);
    chk("midrst_valid", rsp_valid_o, 0);
    chk("midrst_data", rsp_data_o, 0);
    chk("midrst_err", rsp_err_o, 0);
    chk("midrst_cs", rom_cs_o, 0);
    chk("midrst_addr", rom_addr_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_i = 1'b0; addr_i = '0;
    aq = '{16, 17};
    run_list(0, 2, g, at);
    chk("post_rst_grants", g, 2);
    drain();

    wait (done1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
